// File: rtl/sub_bytes_seq.sv
// ---------------------------------------------------------------------------
// sub_bytes_seq
//
// Byte-serial substitution of an NBYTES-wide block through an external,
// registered lookup table (one read per cycle, one edge of read latency).
// A block is latched on start. Its bytes are issued to the LUT one per
// cycle, MSB byte first. Each LUT result is written back into the matching
// byte of dout one edge later. done pulses for one cycle once the final
// byte has been written.
//
// Ports
//   CLK       in   1          clock, rising edge
//   RST       in   1          asynchronous, active-high reset
//   start     in   1          request; only looked at in IDLE
//   din       in   8*NBYTES   block to substitute, byte 0 = MSB byte
//   lut_data  in   8          registered LUT output
//   lut_sel   out  8          LUT byte address (0 whenever lut_en = 0)
//   lut_en    out  1          LUT read enable
//   dout      out  8*NBYTES   substituted block, same byte order as din
//   busy      out  1          high outside IDLE
//   done      out  1          one-cycle completion pulse
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; dout holds the last complete result
// RUN   | issuing byte[idx] to the LUT, capturing the previous byte
// DRAIN | LUT idle; capturing the final byte still in flight
// DONE  | dout complete; done high for this single cycle
// ---------------------------------------------------------------------------
module sub_bytes_seq #(
    parameter int NBYTES = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [8*NBYTES-1:0] din,
    input  logic [7:0]          lut_data,
    output logic [7:0]          lut_sel,
    output logic                lut_en,
    output logic [8*NBYTES-1:0] dout,
    output logic                busy,
    output logic                done
);

    // A one-byte block still needs a one-bit index register.
    localparam int            IW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
    localparam logic [IW-1:0] ONE  = IW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [8*NBYTES-1:0] blk;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       cap_idx;
    logic                cap_vld;

    // The LUT address is decoded straight from state and index, so the byte
    // is presented in the same cycle the index points at it.
    always_comb begin
        lut_en  = 1'b0;
        lut_sel = 8'h00;
        if (state == RUN) begin
            lut_en  = 1'b1;
            lut_sel = blk[8*(NBYTES-1-int'(idx)) +: 8];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            blk     <= '0;
            idx     <= '0;
            cap_idx <= '0;
            cap_vld <= 1'b0;
            dout    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done    <= 1'b0;
            cap_vld <= 1'b0;

            // lut_data now holds the result for the byte issued on the
            // previous edge; only that one byte of dout changes, so the bytes
            // not yet reached keep the previous result.
            if (cap_vld) begin
                dout[8*(NBYTES-1-int'(cap_idx)) +: 8] <= lut_data;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        blk   <= din;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    cap_vld <= 1'b1;
                    cap_idx <= idx;
                    // Index stops at the last byte instead of wrapping.
                    if (idx == LAST) begin
                        state <= DRAIN;
                    end else begin
                        idx <= idx + ONE;
                    end
                end

                DRAIN: begin
                    done  <= 1'b1;
                    state <= DONE;
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// ---------------------------------------------------------------------------
// tb_sub_bytes_seq
//
// Directed bench for sub_bytes_seq (NBYTES = 16) with a behavioural model
// of the registered S-box LUT. Expected results are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_sub_bytes_seq;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         start = 1'b0;
    logic [127:0] din = '0;
    logic [7:0]   lut_data = 8'h00;
    logic [7:0]   lut_sel;
    logic         lut_en;
    logic [127:0] dout;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] V1    = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    localparam logic [127:0] E_V1  = 128'h6CDAC3E9_4E9D0A3D_B836B438_13340CD9;
    localparam logic [127:0] E_Z   = {16{8'h6C}};
    localparam logic [127:0] V3    = 128'hFFC90000_00000000_00000000_00000000;
    localparam logic [127:0] E_V3  = 128'h1D006C6C_6C6C6C6C_6C6C6C6C_6C6C6C6C;
    localparam logic [127:0] VR    = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] E_VR  = 128'hD90C3413_38B436B8_3D0A9D4E_E9C3DA6C;
    localparam logic [127:0] E_MID = 128'hD90C3413_4E9D0A3D_B836B438_13340CD9;

    always #5 CLK = ~CLK;

    sub_bytes_seq #(.NBYTES(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .din      (din),
        .lut_data (lut_data),
        .lut_sel  (lut_sel),
        .lut_en   (lut_en),
        .dout     (dout),
        .busy     (busy),
        .done     (done)
    );

    function automatic logic [7:0] sbox(input logic [7:0] a);
        case (a)
            8'h00: sbox = 8'h6C;  8'h01: sbox = 8'hDA;
            8'h02: sbox = 8'hC3;  8'h03: sbox = 8'hE9;
            8'h04: sbox = 8'h4E;  8'h05: sbox = 8'h9D;
            8'h06: sbox = 8'h0A;  8'h07: sbox = 8'h3D;
            8'h08: sbox = 8'hB8;  8'h09: sbox = 8'h36;
            8'h0A: sbox = 8'hB4;  8'h0B: sbox = 8'h38;
            8'h0C: sbox = 8'h13;  8'h0D: sbox = 8'h34;
            8'h0E: sbox = 8'h0C;  8'h0F: sbox = 8'hD9;
            8'hC9: sbox = 8'h00;  8'hFF: sbox = 8'h1D;
            default: sbox = a ^ 8'hA5;
        endcase
    endfunction

    // Registered LUT: output only moves on an enabled edge.
    always @(posedge CLK) begin
        if (lut_en) lut_data <= sbox(lut_sel);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_op(input logic [127:0] d);
        din   = d;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called #1 after the accepting edge. lat = edges from the accepting edge
    // to the first cycle with done high (-1 if it never came).
    task automatic run_op(input bit hold_start, input bit scramble,
                          output int lat, output int en_cycles, output int en_runs,
                          output int sel_bad, output logic [127:0] snap5);
        bit prev_en;
        lat       = -1;
        en_cycles = 0;
        en_runs   = 0;
        sel_bad   = 0;
        snap5     = '0;
        prev_en   = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (lut_en === 1'b1) begin
                en_cycles++;
                if (!prev_en) en_runs++;
            end else if (lut_sel !== 8'h00) begin
                sel_bad++;
            end
            prev_en = (lut_en === 1'b1);
            if (n == 5) snap5 = dout;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            start = hold_start;
            if (scramble) din = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, en_cycles, en_runs, sel_bad, done_seen;
        logic [127:0] snap;

        // Reset applied without any clock edge
        #1 RST = 1'b1;
        #1;
        check("rst_dout", dout, '0);
        check("rst_ctrl", {busy, done, lut_en, lut_sel}, '0);
        step();
        step();
        RST = 1'b0;
        step();
        step();
        step();
        check("idle_no_start", {busy, done, lut_en, lut_sel}, '0);
        check("idle_dout", dout, '0);

        // Incrementing block
        start_op(V1);
        check("v1_busy", busy, 1'b1);
        check("v1_sel0", lut_sel, 8'h00);
        run_op(0, 0, lat, en_cycles, en_runs, sel_bad, snap);
        check("v1_latency", lat, 17);
        check("v1_dout", dout, E_V1);
        check("v1_sel_idle", sel_bad, 0);
        step();
        check("v1_done_pulse", {busy, done}, 2'b00);

        // All-zero block: LUT enabled for exactly 16 consecutive cycles
        start_op('0);
        run_op(0, 0, lat, en_cycles, en_runs, sel_bad, snap);
        check("z_latency", lat, 17);
        check("z_dout", dout, E_Z);
        check("z_en_cycles", en_cycles, 16);
        check("z_en_runs", en_runs, 1);

        // start held high throughout; second op begins right after DONE
        step();
        din   = V3;
        start = 1'b1;
        step();
        run_op(1, 0, lat, en_cycles, en_runs, sel_bad, snap);
        check("v3_latency", lat, 17);
        check("v3_top16", dout[127:112], 16'h1D00);
        check("v3_dout", dout, E_V3);
        step();
        check("v3_single_done", {busy, done}, 2'b00);
        step();
        check("v3_restart", busy, 1'b1);
        start = 1'b0;
        run_op(0, 0, lat, en_cycles, en_runs, sel_bad, snap);
        check("v3b_latency", lat, 17);
        check("v3b_dout", dout, E_V3);
        step();
        step();
        step();
        step();
        check("v3_dout_hold", dout, E_V3);

        // Reset at RUN index 7
        start_op(V1);
        for (int i = 0; i < 7; i++) step();
        check("abort_sel7", {lut_en, lut_sel}, {1'b1, 8'h07});
        #2 RST = 1'b1;
        #1;
        check("abort_dout", dout, '0);
        check("abort_ctrl", {busy, done, lut_en, lut_sel}, '0);
        done_seen = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (done !== 1'b0) done_seen++;
        end
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done !== 1'b0) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_idle", busy, 1'b0);
        start_op(V1);
        run_op(0, 0, lat, en_cycles, en_runs, sel_bad, snap);
        check("post_abort_latency", lat, 17);
        check("post_abort_dout", dout, E_V1);
        step();

        // din scrambled every cycle during the operation
        start_op(VR);
        run_op(0, 1, lat, en_cycles, en_runs, sel_bad, snap);
        check("scr_partial_dout", snap, E_MID);
        check("scr_latency", lat, 17);
        check("scr_dout", dout, E_VR);
        check("scr_sel_idle", sel_bad, 0);
        check("scr_en_cycles", en_cycles, 16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
